// File: rtl/i2c_slave_controller.sv
// i2c_slave_controller: 7-bit addressed I2C slave with byte-wide receive and transmit handshakes.
module i2c_slave_controller #(
    parameter logic [6:0] SLAVE_ADDR  = 7'b0001000,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       FPGA_clk,
    input  logic       rst,
    input  logic       SCL,
    input  logic       SDA_in,
    output logic       SDA_drive_low,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       selected,
    output logic       busy
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] RX_DATA  = 3'd3;
    localparam logic [2:0] RX_ACK   = 3'd4;
    localparam logic [2:0] TX_DATA  = 3'd5;
    localparam logic [2:0] TX_ACK   = 3'd6;

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;
    logic [7:0]             byte_in;

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [2:0] bit_cnt_q;
    logic [2:0] bit_cnt_d;
    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic [7:0] rx_data_q;
    logic [7:0] rx_data_d;
    logic [7:0] tx_byte_q;
    logic [7:0] tx_byte_d;
    logic       rw_q;
    logic       rw_d;
    logic       done_q;
    logic       done_d;
    logic       drv_q;
    logic       drv_d;
    logic       rx_valid_q;
    logic       rx_valid_d;
    logic       tx_req_q;
    logic       tx_req_d;
    logic       sel_q;
    logic       sel_d;
    logic       busy_q;
    logic       busy_d;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = ~sda_s & sda_prev_q & scl_s;
    assign stop_det  = sda_s & ~sda_prev_q & scl_s;
    assign byte_in   = {shift_q[6:0], sda_s};

    assign SDA_drive_low = drv_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign tx_req        = tx_req_q;
    assign selected      = sel_q;
    assign busy          = busy_q;

    // Bring the bus lines into the clock domain and keep one-cycle-old copies for edge detection.
    always_ff @(posedge FPGA_clk) begin
        if (!rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], SCL};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], SDA_in};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    // Protocol sequencing; bus conditions override any SCL edge seen in the same cycle.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        tx_byte_d  = tx_req_q ? tx_data : tx_byte_q;
        rw_d       = rw_q;
        done_d     = done_q;
        drv_d      = drv_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        sel_d      = sel_q;
        busy_d     = busy_q;
        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            busy_d    = 1'b1;
            sel_d     = 1'b0;
            drv_d     = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            sel_d   = 1'b0;
            drv_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rw_d    = sda_s;
                            state_d = (byte_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : IDLE;
                        end
                    end
                end
                ADDR_ACK, RX_ACK: begin
                    if (scl_fall && !drv_q) begin
                        drv_d = 1'b1;
                        sel_d = 1'b1;
                    end else if (scl_fall) begin
                        drv_d   = 1'b0;
                        state_d = RX_DATA;
                    end else if (scl_rise && drv_q && rw_q) begin
                        tx_req_d = 1'b1;
                        done_d   = 1'b0;
                        state_d  = TX_DATA;
                    end
                end
                RX_DATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                            state_d    = RX_ACK;
                        end
                    end
                end
                TX_DATA: begin
                    if (scl_fall) begin
                        drv_d   = done_q ? 1'b0 : ~tx_byte_q[~bit_cnt_q];
                        state_d = done_q ? TX_ACK : TX_DATA;
                    end else if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        done_d    = (bit_cnt_q == 3'd7);
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        tx_req_d = ~sda_s;
                        done_d   = 1'b0;
                        state_d  = sda_s ? IDLE : TX_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers; reset releases SDA on the very edge it is sampled.
    always_ff @(posedge FPGA_clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'hFF;
            rx_data_q  <= 8'h00;
            tx_byte_q  <= 8'h00;
            rw_q       <= 1'b0;
            done_q     <= 1'b0;
            drv_q      <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            sel_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            tx_byte_q  <= tx_byte_d;
            rw_q       <= rw_d;
            done_q     <= done_d;
            drv_q      <= drv_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_i2c_slave_controller.sv
// tb_i2c_slave_controller: directed bus-master scenarios against the I2C slave.
module tb_i2c_slave_controller;

    localparam int Q = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda;
    logic [7:0] tx_data = 8'h00;
    logic       drv;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       selected;
    logic       busy;

    int total = 0;
    int bad = 0;
    int rxv_n = 0;
    int txr_n = 0;
    int drv_n = 0;
    int busy_lo_n = 0;

    assign sda = m_sda & ~drv;

    i2c_slave_controller dut (
        .FPGA_clk(clk), .rst(rst), .SCL(scl), .SDA_in(sda), .SDA_drive_low(drv),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req),
        .selected(selected), .busy(busy)
    );

    always #5 clk = ~clk;

    // Event counters sampled on the inactive edge.
    always @(negedge clk) begin
        rxv_n     += int'(rx_valid);
        txr_n     += int'(tx_req);
        drv_n     += int'(drv);
        busy_lo_n += int'(!busy);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_c();
        m_sda = 1'b1; #Q; scl = 1'b1; #Q; m_sda = 1'b0; #Q; scl = 1'b0; #Q;
    endtask

    task automatic stop_c();
        m_sda = 1'b0; #Q; scl = 1'b1; #Q; m_sda = 1'b1; #Q;
    endtask

    task automatic bit_w(input logic b);
        m_sda = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic bit_r(output logic b);
        m_sda = 1'b1; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
    endtask

    task automatic byte_w(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_w(d[i]);
        bit_r(s);
        ack = ~s;
    endtask

    task automatic byte_r(output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_r(s);
            d[i] = s;
        end
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        int         b0;
        int         b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("rst_drv", int'(drv), 0);
        chk("rst_rx_data", int'(rx_data), 8'h00);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_tx_req", int'(tx_req), 0);
        chk("rst_selected", int'(selected), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b1;
        #(4*Q);

        b0 = rxv_n;
        start_c();
        byte_w(8'h10, ack);
        chk("wr_addr_ack", int'(ack), 1);
        chk("wr_selected", int'(selected), 1);
        byte_w(8'hA5, ack);
        chk("wr_data_ack", int'(ack), 1);
        chk("wr_rx_data", int'(rx_data), 8'hA5);
        chk("wr_rx_valid_n", rxv_n - b0, 1);
        chk("wr_busy", int'(busy), 1);
        stop_c();
        chk("wr_stop_busy", int'(busy), 0);
        chk("wr_stop_sel", int'(selected), 0);

        b0 = drv_n;
        b1 = rxv_n;
        start_c();
        byte_w(8'h24, ack);
        chk("bad_addr_ack", int'(ack), 0);
        byte_w(8'h5A, ack);
        chk("bad_data_ack", int'(ack), 0);
        stop_c();
        chk("bad_drv_n", drv_n - b0, 0);
        chk("bad_rx_valid_n", rxv_n - b1, 0);
        chk("bad_rx_data", int'(rx_data), 8'hA5);

        tx_data = 8'h3C;
        b0 = txr_n;
        start_c();
        byte_w(8'h11, ack);
        chk("rd_addr_ack", int'(ack), 1);
        byte_r(d);
        chk("rd_byte0", int'(d), 8'h3C);
        tx_data = 8'hF0;
        bit_w(1'b0);
        byte_r(d);
        chk("rd_byte1", int'(d), 8'hF0);
        bit_w(1'b1);
        chk("rd_tx_req_n", txr_n - b0, 2);
        chk("rd_nack_drv", int'(drv), 0);
        chk("rd_nack_busy", int'(busy), 1);
        bit_r(s);
        chk("rd_idle_sda", int'(s), 1);
        stop_c();
        chk("rd_stop_busy", int'(busy), 0);

        tx_data = 8'h96;
        start_c();
        b0 = busy_lo_n;
        byte_w(8'h10, ack);
        chk("rs_wr_ack", int'(ack), 1);
        byte_w(8'h77, ack);
        chk("rs_data_ack", int'(ack), 1);
        chk("rs_rx_data", int'(rx_data), 8'h77);
        start_c();
        chk("rs_sel_clear", int'(selected), 0);
        byte_w(8'h11, ack);
        chk("rs_rd_ack", int'(ack), 1);
        byte_r(d);
        chk("rs_rd_byte", int'(d), 8'h96);
        bit_w(1'b1);
        chk("rs_busy_held", busy_lo_n - b0, 0);
        stop_c();

        start_c();
        for (int i = 7; i >= 0; i--) bit_w(i == 4);
        chk("ackrst_drv_before", int'(drv), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ackrst_drv_after", int'(drv), 0);
        chk("ackrst_sel", int'(selected), 0);
        @(negedge clk);
        stop_c();
        rst = 1'b1;
        #(2*Q);

        start_c();
        byte_w(8'h10, ack);
        chk("mid_addr_ack", int'(ack), 1);
        bit_w(1'b1); bit_w(1'b1); bit_w(1'b0); bit_w(1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_drv", int'(drv), 0);
        chk("mid_sel", int'(selected), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_rx_data", int'(rx_data), 8'h00);
        chk("mid_rx_valid", int'(rx_valid), 0);
        chk("mid_tx_req", int'(tx_req), 0);
        @(negedge clk);
        stop_c();
        rst = 1'b1;
        #(2*Q);
        start_c();
        byte_w(8'h10, ack);
        chk("post_addr_ack", int'(ack), 1);
        byte_w(8'h5A, ack);
        chk("post_data_ack", int'(ack), 1);
        chk("post_rx_data", int'(rx_data), 8'h5A);
        stop_c();
        chk("post_busy", int'(busy), 0);

        start_c();
        for (int i = 7; i >= 1; i--) bit_w(i == 4);
        m_sda = 1'b0; #Q; scl = 1'b1; #Q;
        chk("aa_busy_before", int'(busy), 1);
        m_sda = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("aa_busy_after", int'(busy), 0);
        chk("aa_drv_after", int'(drv), 0);
        @(negedge clk);
        scl = 1'b0;
        #(2*Q);
        chk("aa_drv_low_phase", int'(drv), 0);
        chk("aa_sel", int'(selected), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave_controller.md
I2C_SLAVE_CONTROLLER -- requirements
Module: i2c_slave_controller

Interface
REQ-001 The block SHALL have parameter SLAVE_ADDR, default 7'b0001000, the 7-bit address this slave answers to.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth for SCL and SDA (minimum 2).
REQ-003 Port FPGA_clk  input  1  system clock; SHALL run at least 8x faster than SCL.
REQ-004 Port rst  input  1  reset; synchronous and active-low.
REQ-005 Port SCL  input  1  I2C bus clock (asynchronous to FPGA_clk).
REQ-006 Port SDA_in  input  1  I2C bus data as read from the pad.
REQ-007 Port SDA_drive_low  output  1  open-drain control: 1 pulls SDA low, 0 releases it.
REQ-008 Port rx_data  output  8  last received data byte.
REQ-009 Port rx_valid  output  1  one-cycle pulse; rx_data is updated in the same cycle.
REQ-010 Port tx_data  input  8  byte to transmit; latched when tx_req pulses.
REQ-011 Port tx_req  output  1  one-cycle pulse requesting tx_data.
REQ-012 Port selected  output  1  high from address ACK until STOP or repeated START.
REQ-013 Port busy  output  1  high between a detected START and a detected STOP.

Function
REQ-014 SCL and SDA_in SHALL each pass through a SYNC_STAGES flop synchronizer.
REQ-015 Edges SHALL be detected by comparing the synchronized value with a one-cycle-delayed copy.
REQ-016 START SHALL be detected as a synchronized SDA fall while synchronized SCL is high.
REQ-017 STOP SHALL be detected as a synchronized SDA rise while synchronized SCL is high.
REQ-018 FSM states SHALL be IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK.
REQ-019 START in any state, including a repeated START, SHALL enter ADDR, clear the bit counter, set busy, clear selected and release SDA.
REQ-020 STOP in any state SHALL enter IDLE, clear busy and selected, and release SDA.
REQ-021 ADDR: the block SHALL shift SDA MSB-first on each SCL rising edge; after 8 bits, bits[7:1] are the address and bit[0] is R/W.
REQ-022 On address match the FSM SHALL enter ADDR_ACK; on mismatch it SHALL enter IDLE without driving SDA until the next START.
REQ-023 ADDR_ACK: SDA_drive_low SHALL assert on the first SCL falling edge after the 8th bit and deassert on the next falling edge; selected SHALL assert on that first falling edge.
REQ-024 ADDR_ACK with R/W=0: the FSM SHALL go to RX_DATA when the ACK is released.
REQ-025 ADDR_ACK with R/W=1: tx_req SHALL pulse on the ACK's rising SCL edge; tx_data SHALL be latched that cycle+1 and the FSM SHALL go to TX_DATA.
REQ-026 RX_DATA: the block SHALL shift 8 bits on rising edges; on the 8th, rx_data SHALL update and rx_valid SHALL pulse within 1 FPGA_clk, then the FSM SHALL go to RX_ACK.
REQ-027 RX_ACK: the slave SHALL always ACK with the same timing as REQ-023, then return to RX_DATA.
REQ-028 TX_DATA: SDA_drive_low SHALL equal ~bit on each SCL falling edge, MSB first, starting with the falling edge that ends the ACK; after the 8th bit's falling edge the FSM SHALL release SDA and enter TX_ACK.
REQ-029 TX_ACK: master ACK (SDA=0) sampled on the rising edge SHALL pulse tx_req, latch the next byte and return to TX_DATA.
REQ-030 TX_ACK: master NACK SHALL enter IDLE with SDA released and busy held until STOP.
REQ-031 The bit counter SHALL be 3 bits and wrap 7->0 at byte end; it SHALL never count without a SCL rising edge.
REQ-032 If START/STOP and an SCL edge are detected in the same cycle, START/STOP SHALL take priority.

Reset
REQ-033 With rst=0 at a FPGA_clk edge: state=IDLE; SDA_drive_low, rx_valid, tx_req, selected and busy = 0; rx_data = 8'h00; shift register, bit counter and synchronizers = idle-bus values (1 for SCL/SDA).
REQ-034 Reset mid-transfer SHALL release SDA within the same clock edge.
REQ-035 After reset the block SHALL ignore the bus until a new START.

Verification
REQ-036 Write to 0x08 followed by data 0xA5 -> ACK after the address (selected=1), rx_data=0xA5 with one rx_valid pulse, ACK after the data, STOP -> busy=0.
REQ-037 Address 0x12 (write) followed by a byte -> no ACK, SDA_drive_low stays 0 for the whole frame, and rx_valid never pulses.
REQ-038 Read from 0x08 with tx_data=0x3C then 0xF0, master ACKs then NACKs -> bus bits 00111100 then 11110000, exactly two tx_req pulses, IDLE after the NACK.
REQ-039 Write 0x08 with one byte, repeated START, then read 0x08 -> second address ACKed, R/W=1 path taken, and busy held high throughout.
REQ-040 rst=0 asserted at the 4th data bit of a write -> next edge gives all outputs at reset values and SDA released; a later clean transfer succeeds.
REQ-041 STOP issued during ADDR_ACK -> SDA released and IDLE within SYNC_STAGES+2 cycles of the SDA rise.
